vppm_modulator: RTL
===================

VPPM_MODULATOR -- requirements
Module: vppm_modulator

Interface
REQ-001 Parameter NBITS2, default 12: symbol counter width; one VPPM symbol lasts 2**NBITS2 clock cycles.
REQ-002 Parameter NBDATA, default 8: bits per transmitted word.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port tx_data  input  NBDATA  word to transmit, MSB first.
REQ-006 Port tx_valid  input  1  tx_data valid request.
REQ-007 Port tx_ready  output  1  block can accept a word this cycle.
REQ-008 Port duty  input  NBITS2  pulse width in clocks (dimming level), unsigned.
REQ-009 Port vppm_out  output  1  registered VPPM drive to LED.
REQ-010 Port sym_count  output  NBITS2  registered position within current symbol.
REQ-011 Port busy  output  1  high while a word is on the line.

Function
REQ-012 The block SHALL implement states IDLE, PRE (preamble, macro-dependent) and DATA.
REQ-013 The block SHALL set tx_ready high only in IDLE, and a transfer SHALL occur on a rising edge with tx_valid and tx_ready both high.
REQ-014 On transfer the block SHALL latch tx_data and duty (duty_q), clear sym_count to 0 and enter PRE (macro defined) or DATA (macro undefined) on that edge.
REQ-015 In PRE/DATA sym_count SHALL increment by 1 per clock and wrap from 2**NBITS2-1 to 0; each wrap SHALL advance to the next symbol.
REQ-016 The block SHALL treat symbol bit 0 as a pulse at symbol start: vppm_out high iff sym_count < duty_q.
REQ-017 The block SHALL treat symbol bit 1 as a pulse at symbol end: vppm_out high iff sym_count >= 2**NBITS2 - duty_q.
REQ-018 The vppm_out and sym_count registers SHALL update on the same edge so the REQ-016/017 relation holds in every cycle with zero skew.
REQ-019 The block SHALL send data bits MSB first, one per symbol, NBDATA symbols per word.
REQ-020 After the last clock of the last data symbol the block SHALL return to IDLE, with vppm_out=0 and sym_count=0 in IDLE.
REQ-021 The block SHALL therefore leave at least one IDLE cycle between words (back-to-back period = symbols*2**NBITS2 + 1 clocks).
REQ-022 With duty_q=0, vppm_out SHALL stay low for the whole word while busy remains high; duty max 2**NBITS2-1 means the line is never fully on.
REQ-023 Changes of duty or tx_data after transfer SHALL be ignored until the next transfer.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 While rst_n is low the block SHALL immediately force state=IDLE, vppm_out=0, sym_count=0, busy=0, tx_ready=0, duty_q=0 and the data shift register to 0.
REQ-026 A reset asserted mid-word SHALL abort the word and not resume it; tx_ready SHALL rise on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro VPPM_PREAMBLE_EN defined: each word SHALL be preceded by 4 PRE symbols with bit sequence 1,0,1,0 using duty_q; word length = (NBDATA+4) symbols.
REQ-028 Macro VPPM_PREAMBLE_EN undefined: PRE state and its logic SHALL not exist; a transfer goes straight to DATA; word length = NBDATA symbols.

Verification (NBITS2=4, 16-clock symbols, NBDATA=8)
REQ-029 Reset: rst_n low mid-run -> vppm_out, busy, sym_count 0 at once; tx_ready 1 one edge after release.
REQ-030 No macro, tx_data=0x80, duty=4 -> symbol 0 high at counts 12..15; symbols 1..7 high at counts 0..3; busy 128 clocks, then tx_ready=1.
REQ-031 No macro, tx_data=0xFF, duty=0 -> vppm_out never high; busy for 128 clocks.
REQ-032 VPPM_PREAMBLE_EN, tx_data=0x00, duty=8 -> preamble pulses at 8..15, 0..7, 8..15, 0..7, then 8 symbols high at 0..7; busy 192 clocks.
REQ-033 duty changed from 4 to 10 at clock 20 of a word -> all remaining pulses stay 4 clocks wide; the next word uses 10.
REQ-034 tx_valid held high continuously with alternating 0xA5/0x5A -> each word accepted in IDLE only, words separated by exactly 1 idle cycle, no word lost or duplicated.

Source files
------------

// File: rtl/vppm_modulator.sv
// ---------------------------------------------------------------------------
// vppm_modulator
//
// Variable pulse-position modulator for an LED drive. Each data bit occupies
// one symbol of 2**NBITS2 clocks. A '0' bit is a pulse of duty_q clocks at
// the start of the symbol. A '1' bit is a pulse of duty_q clocks at the end
// of the symbol. Words are sent MSB first. After the last symbol the block
// spends at least one cycle in IDLE before it accepts the next word.
//
// Optional feature (compile-time macro VPPM_PREAMBLE_EN):
//   When this macro is defined, each word is preceded by four preamble
//   symbols with the bit pattern 1,0,1,0. The preamble uses the latched
//   duty value. When the macro is not defined, the preamble state and its
//   logic are not built.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tx_data    word to transmit (NBDATA bits, MSB first)
//   tx_valid   request to transmit tx_data
//   tx_ready   block accepts a word this cycle (IDLE only)
//   duty       pulse width in clocks (dimming level)
//   vppm_out   registered LED drive
//   sym_count  registered position within the current symbol
//   busy       high while a word is on the line
// ---------------------------------------------------------------------------
module vppm_modulator #(
    parameter int NBITS2 = 12,
    parameter int NBDATA = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NBDATA-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [NBITS2-1:0] duty,
    output logic              vppm_out,
    output logic [NBITS2-1:0] sym_count,
    output logic              busy
);

    localparam int IDX_W = (NBDATA > 1) ? $clog2(NBDATA) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBDATA - 1);
    localparam logic [NBITS2:0]   SYM_LEN  = {1'b1, {NBITS2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef VPPM_PREAMBLE_EN
        S_PRE  = 2'd1,
`endif
        S_DATA = 2'd2
    } state_t;

    state_t              state;
    logic [NBITS2-1:0]   duty_q;
    logic [NBDATA-1:0]   shreg;
    logic [IDX_W-1:0]    bit_idx;
`ifdef VPPM_PREAMBLE_EN
    logic [1:0]          pre_idx;
`endif

    logic [NBITS2-1:0]   count_inc;
    logic                count_wrap;

    assign count_inc  = sym_count + 1'b1;
    assign count_wrap = &sym_count;

    // The drive level for a given bit at a given position inside its symbol.
    // Callers pass the new sym_count value, so the output register and the
    // counter register are updated on the same edge and stay consistent.
    // The '1' threshold is computed at NBITS2+1 bits so that duty 0 never
    // asserts the drive.
    function automatic logic pulse(input logic b,
                                   input logic [NBITS2-1:0] c,
                                   input logic [NBITS2-1:0] d);
        if (b)
            return ({1'b0, c} >= (SYM_LEN - {1'b0, d}));
        else
            return (c < d);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vppm_out  <= 1'b0;
            sym_count <= '0;
            busy      <= 1'b0;
            tx_ready  <= 1'b0;
            duty_q    <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
`ifdef VPPM_PREAMBLE_EN
            pre_idx   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    sym_count <= '0;
                    vppm_out  <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        duty_q   <= duty;
                        shreg    <= tx_data;
                        bit_idx  <= '0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
`ifdef VPPM_PREAMBLE_EN
                        pre_idx  <= '0;
                        state    <= S_PRE;
                        vppm_out <= pulse(1'b1, '0, duty);
`else
                        state    <= S_DATA;
                        vppm_out <= pulse(tx_data[NBDATA-1], '0, duty);
`endif
                    end else begin
                        // This also raises tx_ready on the first edge after reset.
                        tx_ready <= 1'b1;
                    end
                end
`ifdef VPPM_PREAMBLE_EN
                // The preamble bit for symbol index i is ~i[0], which gives 1,0,1,0.
                S_PRE: begin
                    sym_count <= count_inc;
                    if (count_wrap) begin
                        if (pre_idx == 2'd3) begin
                            state    <= S_DATA;
                            vppm_out <= pulse(shreg[NBDATA-1], '0, duty_q);
                        end else begin
                            pre_idx  <= pre_idx + 2'd1;
                            vppm_out <= pulse(pre_idx[0], '0, duty_q);
                        end
                    end else begin
                        vppm_out <= pulse(~pre_idx[0], count_inc, duty_q);
                    end
                end
`endif
                S_DATA: begin
                    sym_count <= count_inc;
                    if (count_wrap) begin
                        if (bit_idx == LAST_IDX) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                            vppm_out <= 1'b0;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shreg    <= shreg << 1;
                            vppm_out <= pulse(shreg[NBDATA-2], '0, duty_q);
                        end
                    end else begin
                        vppm_out <= pulse(shreg[NBDATA-1], count_inc, duty_q);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    vppm_out  <= 1'b0;
                    sym_count <= '0;
                end
            endcase
        end
    end

endmodule
